parking_alert: RTL
==================

# parking_alert

Parking-assist alert generator that sits directly downstream of the distance detection stage. It consumes the registered `front_distance` / `rear_distance` values (5-bit feet, 0 = no object), classifies the nearest object into a proximity band, and drives a buzzer cadence and side-warning lamps. Bands escalate immediately and de-escalate with hysteresis, so the alert never relaxes on a single noisy sample.

## Interface
- `TICK_DIV`, 4: clock cycles per beep tick (≥2)
- `ON_TICKS`, 2: ticks the buzzer is on per beep
- `FAR_PERIOD`, 16: beep period in ticks, FAR band (> ON_TICKS)
- `MID_PERIOD`, 8: beep period in ticks, MID band (> ON_TICKS)
- `NEAR_PERIOD`, 4: beep period in ticks, NEAR band (> ON_TICKS)
- `RELEASE_CYC`, 8: consecutive cycles a farther band must persist before de-escalation (≥1)
- `CLK`  in  1  system clock, rising edge
- `RST`  in  1  asynchronous reset, active-high
- `active`  in  1  alert enable (reverse gear / low speed); low forces silence
- `front_distance`  in  5  front object distance, feet; 0 = none
- `rear_distance`  in  5  rear object distance, feet; 0 = none
- `buzzer`  out  1  buzzer drive
- `band`  out  3  current effective band: 0 NONE, 1 FAR, 2 MID, 3 NEAR, 4 CRIT
- `front_warn`  out  1  object present in front
- `rear_warn`  out  1  object present at rear

## Operation
- Raw band, combinational per cycle: d = min of nonzero inputs (both 0 → NONE). d 16–31 FAR, 11–15 MID, 6–10 NEAR, 1–5 CRIT. Unsigned compares only.
- Effective band register `band`:
  - raw > band: band ← raw at next edge; release counter cleared.
  - raw == band: release counter cleared.
  - raw < band: release counter increments. When it reaches RELEASE_CYC, band ← raw at that edge and the counter clears. Any cycle with raw ≥ band clears the counter.
- `active` low: band ← NONE, counters clear, FSM → IDLE, all outputs 0 next edge.
- `front_warn` / `rear_warn`: registered (input ≠ 0) && active. Both may be 1.
- Beep FSM states: IDLE, BEEP_ON, BEEP_OFF, SOLID.
  - Restart on any edge where `band` changed, which clears the prescaler and tick counter. New band NONE → IDLE; CRIT → SOLID; FAR/MID/NEAR → BEEP_ON.
  - BEEP_ON → BEEP_OFF after ON_TICKS ticks. BEEP_OFF → BEEP_ON after (PERIOD − ON_TICKS) ticks, where PERIOD is the current band's period.
  - IDLE and SOLID hold until the next band change.
- Prescaler: counts 0..TICK_DIV−1 and emits a tick on wrap. Counter widths are sized from the parameters with no overflow.
- `buzzer` is a registered decode: 1 in BEEP_ON or SOLID, else 0.

## Timing
- Reset (async) values: band 0, buzzer 0, front_warn 0, rear_warn 0, FSM IDLE, all counters 0.
- Latency:
  - Input to `band`: 1 cycle on escalation; RELEASE_CYC cycles on de-escalation.
  - `band` change to `buzzer` change: 1 cycle, so 2 cycles input-to-buzzer on escalation.
  - Input to warn outputs: 1 cycle.
- Beep timing: BEEP_ON lasts exactly ON_TICKS×TICK_DIV cycles; BEEP_OFF lasts (PERIOD−ON_TICKS)×TICK_DIV cycles.
- A band change mid-beep restarts the cadence at BEEP_ON at once. There is no completion of the current beep.
- If escalation and a release-count expiry coincide, escalation wins.
- RST asserted mid-beep: outputs drop to reset values immediately, asynchronously. Operation resumes from IDLE on the first edge after release.

## Test plan
- FAR cadence: active=1, front=20 held → band=1 after 1 cycle; buzzer high 8 cycles, low 56, repeating; front_warn=1, rear_warn=0.
- Nearest wins: front=12, rear=3 → band=4, buzzer solid 1 from cycle 2, both warns 1. Then rear=0 → band stays 4 for 8 cycles, then 2 (MID, 8-on/24-off).
- Hysteresis flicker: alternate distance 4/10 every 3 cycles → band stays 4 and buzzer stays 1 throughout. Hold 10 → band=3 exactly 8 cycles after the last 4.
- Escalation mid-beep: FAR, 3 cycles into BEEP_ON, front=8 → band=3 next edge; cadence restarts with 8-on/8-off.
- Disable and clear: active→0 during SOLID → next edge all outputs 0. Both distances 0 with active=1 → band 0, buzzer 0.
- Reset mid-operation: RST pulse during BEEP_OFF → outputs 0 immediately. After release with front=5 → band=4 after 1 edge, buzzer 1 after 2.

Source files
------------

// File: rtl/parking_alert.sv
// parking_alert
// -----------------------------------------------------------------------------
// Parking-assist alert generator. Takes the registered front/rear object
// distances (5-bit feet, 0 = no object), classifies the nearest object into a
// proximity band, and drives a buzzer cadence plus front/rear warning lamps.
// Bands escalate on the next edge and only de-escalate after the farther band
// has persisted for RELEASE_CYC consecutive cycles.
//
// There is no handshake on this block: inputs are sampled every cycle and
// outputs are plain registered levels.
//
// Ports:
//   CLK            in   1  system clock, rising edge
//   RST            in   1  asynchronous reset, active-high
//   active         in   1  alert enable; low forces band NONE and silence
//   front_distance in   5  front object distance, feet; 0 = none
//   rear_distance  in   5  rear object distance, feet; 0 = none
//   buzzer         out  1  buzzer drive (registered)
//   band           out  3  effective band: 0 NONE, 1 FAR, 2 MID, 3 NEAR, 4 CRIT
//   front_warn     out  1  front object present (registered, gated by active)
//   rear_warn      out  1  rear object present (registered, gated by active)
//   fsm_state      out  2  beep FSM state: 0 IDLE, 1 BEEP_ON, 2 BEEP_OFF, 3 SOLID
// -----------------------------------------------------------------------------
module parking_alert #(
  parameter int TICK_DIV    = 4,
  parameter int ON_TICKS    = 2,
  parameter int FAR_PERIOD  = 16,
  parameter int MID_PERIOD  = 8,
  parameter int NEAR_PERIOD = 4,
  parameter int RELEASE_CYC = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       active,
  input  logic [4:0] front_distance,
  input  logic [4:0] rear_distance,
  output logic       buzzer,
  output logic [2:0] band,
  output logic       front_warn,
  output logic       rear_warn,
  output logic [1:0] fsm_state
);

  localparam logic [2:0] BAND_NONE = 3'd0;
  localparam logic [2:0] BAND_FAR  = 3'd1;
  localparam logic [2:0] BAND_MID  = 3'd2;
  localparam logic [2:0] BAND_NEAR = 3'd3;
  localparam logic [2:0] BAND_CRIT = 3'd4;

  localparam int MAX_P12 = (FAR_PERIOD > MID_PERIOD) ? FAR_PERIOD : MID_PERIOD;
  localparam int MAX_PER = (MAX_P12 > NEAR_PERIOD) ? MAX_P12 : NEAR_PERIOD;

  // Prescaler holds 0..TICK_DIV-1, tick counter holds at most MAX_PER-1,
  // release counter holds at most RELEASE_CYC-1.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = $clog2(MAX_PER + 1);
  localparam int RW = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_OFF   = 2'd2,
    ST_SOLID = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [PW-1:0]   presc;
  logic [TW-1:0]   tick_cnt;
  logic [RW-1:0]   rel_cnt, rel_next;
  logic [2:0]      band_next;
  logic [2:0]      raw_band;
  logic [4:0]      d_min;
  logic            band_chg;
  logic            tick;
  logic [TW-1:0]   off_last;
  logic            phase_done;
  logic            buzzer_d;

  // ---------------------------------------------------------------------------
  // Raw band from the nearest nonzero distance
  // ---------------------------------------------------------------------------
  always_comb begin
    d_min = 5'd0;
    if (front_distance == 5'd0)
      d_min = rear_distance;
    else if (rear_distance == 5'd0)
      d_min = front_distance;
    else if (front_distance < rear_distance)
      d_min = front_distance;
    else
      d_min = rear_distance;
  end

  always_comb begin
    raw_band = BAND_NONE;
    if (d_min == 5'd0)
      raw_band = BAND_NONE;
    else if (d_min >= 5'd16)
      raw_band = BAND_FAR;
    else if (d_min >= 5'd11)
      raw_band = BAND_MID;
    else if (d_min >= 5'd6)
      raw_band = BAND_NEAR;
    else
      raw_band = BAND_CRIT;
  end

  // ---------------------------------------------------------------------------
  // Effective band with release hysteresis. Escalation is tested first so it
  // wins over a release expiry in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    band_next = band;
    rel_next  = rel_cnt;
    if (!active) begin
      band_next = BAND_NONE;
      rel_next  = '0;
    end else if (raw_band > band) begin
      band_next = raw_band;
      rel_next  = '0;
    end else if (raw_band == band) begin
      rel_next  = '0;
    end else if (rel_cnt == RW'(RELEASE_CYC - 1)) begin
      // Counter would reach RELEASE_CYC on this edge: release now.
      band_next = raw_band;
      rel_next  = '0;
    end else begin
      rel_next  = rel_cnt + 1'b1;
    end
  end

  assign band_chg = (band_next != band);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      band    <= BAND_NONE;
      rel_cnt <= '0;
    end else begin
      band    <= band_next;
      rel_cnt <= rel_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Cadence timing
  // ---------------------------------------------------------------------------
  assign tick = (presc == PW'(TICK_DIV - 1));

  // Last tick index of the off phase for the current band.
  always_comb begin
    off_last = '0;
    case (band)
      BAND_FAR:  off_last = TW'(FAR_PERIOD  - ON_TICKS - 1);
      BAND_MID:  off_last = TW'(MID_PERIOD  - ON_TICKS - 1);
      BAND_NEAR: off_last = TW'(NEAR_PERIOD - ON_TICKS - 1);
      default:   off_last = '0;
    endcase
  end

  always_comb begin
    phase_done = 1'b0;
    if (tick) begin
      if (state == ST_ON)
        phase_done = (tick_cnt == TW'(ON_TICKS - 1));
      else if (state == ST_OFF)
        phase_done = (tick_cnt == off_last);
    end
  end

  // Any band change (including a forced drop to NONE) restarts the cadence,
  // so both counters clear on that edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc    <= '0;
      tick_cnt <= '0;
    end else if (!active || band_chg) begin
      presc    <= '0;
      tick_cnt <= '0;
    end else if (state == ST_ON || state == ST_OFF) begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick)
        tick_cnt <= phase_done ? '0 : tick_cnt + 1'b1;
    end else begin
      presc    <= '0;
      tick_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Beep FSM: state register / next state / output decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!active) begin
      state_next = ST_IDLE;
    end else if (band_chg) begin
      case (band_next)
        BAND_NONE: state_next = ST_IDLE;
        BAND_CRIT: state_next = ST_SOLID;
        default:   state_next = ST_ON;
      endcase
    end else begin
      case (state)
        ST_ON:   if (phase_done) state_next = ST_OFF;
        ST_OFF:  if (phase_done) state_next = ST_ON;
        default: state_next = state;
      endcase
    end
  end

  // Gating by active makes the buzzer drop on the same edge that disables
  // the block, rather than one edge after the FSM reaches IDLE.
  always_comb begin
    buzzer_d = 1'b0;
    if (active && (state == ST_ON || state == ST_SOLID))
      buzzer_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      buzzer     <= 1'b0;
      front_warn <= 1'b0;
      rear_warn  <= 1'b0;
    end else begin
      buzzer     <= buzzer_d;
      front_warn <= active && (front_distance != 5'd0);
      rear_warn  <= active && (rear_distance  != 5'd0);
    end
  end

  assign fsm_state = state;

endmodule
